pc_ctrl: RTL and testbench



---
 rtl/pc_ctrl_pkg.sv | 23 ++
 rtl/pc_redirect_mux.sv | 45 ++++
 rtl/pc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl_pkg
// Description : Shared definitions for the next-PC sequencer: FSM state
//               encodings, PC width and the default sequential increment.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    localparam int PC_W = 16;

    // Default byte step between consecutive 16-bit instructions
    localparam logic [PC_W-1:0] INC_DEFAULT = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_PEND = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/pc_redirect_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_mux
// Description : Combinational priority select between the EX-stage branch
//               and the ID-stage jump. The branch belongs to the older
//               instruction, so it wins and also squashes the ID/EX slot.
// Ports       : br_taken_i/br_target_i  - EX branch resolved taken + target
//               jmp_i/jmp_target_i      - ID jump decoded + target
//               redir_o                 - some redirect is requested
//               tgt_o                   - selected redirect target
//               flush_if_o/flush_id_o   - flushes belonging to that redirect
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_mux
    import pc_ctrl_pkg::*;
(
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jmp_target_i,
    output logic            redir_o,
    output logic [PC_W-1:0] tgt_o,
    output logic            flush_if_o,
    output logic            flush_id_o
);

    always_comb begin
        redir_o    = 1'b0;
        tgt_o      = jmp_target_i;
        flush_if_o = 1'b0;
        flush_id_o = 1'b0;
        if (br_taken_i) begin
            redir_o    = 1'b1;
            tgt_o      = br_target_i;
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
        end else if (jmp_i) begin
            redir_o    = 1'b1;
            tgt_o      = jmp_target_i;
            flush_if_o = 1'b1;
        end
    end

endmodule : pc_redirect_mux
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Next-PC sequencer. Chooses the D value and write enable of
//               the external PC register each cycle (increment, branch,
//               jump, hazard hold, fetch-wait hold, halt), raises IF/ID
//               flushes and counts stalled cycles (saturating).
// Ports       : clk, rst_n            - clock, async active-low reset
//               pc_cur                - PC register output fed back
//               imem_ready            - fetch of pc_cur completes this cycle
//               hazard_stall          - load-use hold from ID
//               br_taken/br_target    - EX branch redirect
//               jmp/jmp_target        - ID jump redirect
//               halt_req/resume       - enter / leave HALT
//               pc_next/pc_wen        - PC register D input / enable
//               flush_if/flush_id     - squash IF/ID, ID/EX
//               halted                - in HALT
//               stall_cnt             - stalled cycles outside HALT
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [15:0] INC   = INC_DEFAULT,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc_cur,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             br_taken,
    input  logic [15:0]      br_target,
    input  logic             jmp,
    input  logic [15:0]      jmp_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [15:0]      pc_next,
    output logic             pc_wen,
    output logic             flush_if,
    output logic             flush_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic [15:0]      pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             w_redir;
    logic [15:0]      w_tgt;
    logic             w_fl_if;
    logic             w_fl_id;
    logic [15:0]      w_pc_seq;
    logic [15:0]      w_pend_sel;

    pc_redirect_mux u_redirect_mux (
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .redir_o      (w_redir),
        .tgt_o        (w_tgt),
        .flush_if_o   (w_fl_if),
        .flush_id_o   (w_fl_id)
    );

    // Wraps modulo 2^16 by construction
    assign w_pc_seq = pc_cur + INC;

    // A branch arriving in PEND is newer than the latched target
    assign w_pend_sel = br_taken ? br_target : pend_tgt_q;

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pc_next    = pc_cur;
        pc_wen     = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        halted     = 1'b0;
        // Outputs are gated by rst_n so nothing is written while reset is held
        if (rst_n) begin
            unique case (state_q)
                ST_RUN, ST_WAIT: begin
                    if (state_q == ST_RUN || imem_ready) begin
                        if (w_redir) begin
                            flush_if = w_fl_if;
                            flush_id = w_fl_id;
                            if (imem_ready) begin
                                pc_next = w_tgt;
                                pc_wen  = 1'b1;
                                state_d = ST_RUN;
                            end else begin
                                // Fetch outstanding: park the target
                                pend_tgt_d = w_tgt;
                                state_d    = ST_PEND;
                            end
                        end else if (halt_req) begin
                            flush_if = 1'b1;
                            state_d  = ST_HALT;
                        end else if (hazard_stall) begin
                            state_d = ST_RUN;
                        end else if (!imem_ready) begin
                            state_d = ST_WAIT;
                        end else begin
                            pc_next = w_pc_seq;
                            pc_wen  = 1'b1;
                            state_d = ST_RUN;
                        end
                    end else if (w_redir) begin
                        // WAIT with fetch still outstanding: only redirects act
                        flush_if   = w_fl_if;
                        flush_id   = w_fl_id;
                        pend_tgt_d = w_tgt;
                        state_d    = ST_PEND;
                    end
                end
                ST_PEND: begin
                    // The in-flight fetch belongs to the old path
                    flush_if = 1'b1;
                    if (br_taken) begin
                        flush_id   = 1'b1;
                        pend_tgt_d = br_target;
                    end
                    if (imem_ready) begin
                        pc_next = w_pend_sel;
                        pc_wen  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && state_q != ST_HALT && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pend_tgt_q  <= 16'h0000;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_tgt_q  <= pend_tgt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule : pc_ctrl
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Self-checking bench for pc_ctrl. Each stimulus cycle pushes
//               a hand-computed expectation into a queue; a monitor on the
//               falling edge pops and compares it against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

    typedef struct {
        logic [15:0] pc_next;
        bit          chk_pc;
        logic        wen;
        logic        fi;
        logic        fd;
        logic        halted;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_cur;
    logic        imem_ready;
    logic        hazard_stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        halt_req;
    logic        resume;
    logic [15:0] pc_next;
    logic        pc_wen;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic [15:0] stall_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.INC(16'd2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_cur       (pc_cur),
        .imem_ready   (imem_ready),
        .hazard_stall (hazard_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_next      (pc_next),
        .pc_wen       (pc_wen),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cyc%0d %s: got %h expected %h", c, name, act, req);
        end
    endtask

    // Monitor: one expectation is consumed per cycle, away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_pc) chk("pc_next", e.cyc, pc_next, e.pc_next);
            chk("pc_wen",    e.cyc, {15'd0, pc_wen},   {15'd0, e.wen});
            chk("flush_if",  e.cyc, {15'd0, flush_if}, {15'd0, e.fi});
            chk("flush_id",  e.cyc, {15'd0, flush_id}, {15'd0, e.fd});
            chk("halted",    e.cyc, {15'd0, halted},   {15'd0, e.halted});
            chk("stall_cnt", e.cyc, stall_cnt, e.cnt);
        end
    end

    task automatic idle_inputs();
        imem_ready   = 1'b1;
        hazard_stall = 1'b0;
        br_taken     = 1'b0;
        br_target    = 16'h0000;
        jmp          = 1'b0;
        jmp_target   = 16'h0000;
        halt_req     = 1'b0;
        resume       = 1'b0;
    endtask

    // Push the expectation for the current input set, then advance one cycle
    task automatic step(input logic [15:0] pcn, input bit chk_pc, input logic wen,
                        input logic fi, input logic fd, input logic h, input logic [15:0] cnt);
        exp_t e;
        e.pc_next = pcn; e.chk_pc = chk_pc; e.wen = wen; e.fi = fi;
        e.fd = fd; e.halted = h; e.cnt = cnt; e.cyc = cyc;
        q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        pc_cur = 16'h1234;
        @(posedge clk);
        #1;
        // Reset: outputs quiet, pc_next follows pc_cur
        step(16'h1234, 1, 0, 0, 0, 0, 16'd0);
        rst_n = 1'b1;

        // 1. sequential fetch
        pc_cur = 16'h0000; step(16'h0002, 1, 1, 0, 0, 0, 16'd0);
        pc_cur = 16'h0002; step(16'h0004, 1, 1, 0, 0, 0, 16'd0);
        pc_cur = 16'h0004; step(16'h0006, 1, 1, 0, 0, 0, 16'd0);

        // 2. branch beats jump
        pc_cur = 16'h0010; br_taken = 1; br_target = 16'h0100; jmp = 1; jmp_target = 16'h0200;
        step(16'h0100, 1, 1, 1, 1, 0, 16'd0);
        idle_inputs();

        // 3. jump with fetch outstanding for 3 cycles
        pc_cur = 16'h0020; jmp = 1; jmp_target = 16'h0300; imem_ready = 0;
        step(16'h0000, 0, 0, 1, 0, 0, 16'd0);
        jmp = 0;
        step(16'h0000, 0, 0, 1, 0, 0, 16'd1);
        step(16'h0000, 0, 0, 1, 0, 0, 16'd2);
        imem_ready = 1;
        step(16'h0300, 1, 1, 1, 0, 0, 16'd3);

        // 4. halt, 10 held cycles (one with a branch that must be ignored), resume
        pc_cur = 16'h0040; halt_req = 1;
        step(16'h0000, 0, 0, 1, 0, 0, 16'd3);
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            br_taken = (i == 3); br_target = 16'h0BAD;
            step(16'h0000, 0, 0, 0, 0, 1, 16'd4);
        end
        br_taken = 0; resume = 1;
        step(16'h0000, 0, 0, 0, 0, 1, 16'd4);
        resume = 0;
        step(16'h0042, 1, 1, 0, 0, 0, 16'd4);

        // 5. wrap, then hazard hold for 2 cycles
        pc_cur = 16'hFFFE; step(16'h0000, 1, 1, 0, 0, 0, 16'd4);
        pc_cur = 16'h0000; hazard_stall = 1;
        step(16'h0000, 0, 0, 0, 0, 0, 16'd4);
        step(16'h0000, 0, 0, 0, 0, 0, 16'd5);
        hazard_stall = 0;
        step(16'h0002, 1, 1, 0, 0, 0, 16'd6);

        // branch coincident with halt_req: branch wins; resume in RUN is inert
        pc_cur = 16'h0050; br_taken = 1; br_target = 16'h0500; halt_req = 1;
        step(16'h0500, 1, 1, 1, 1, 0, 16'd6);
        idle_inputs();
        pc_cur = 16'h0500; resume = 1;
        step(16'h0502, 1, 1, 0, 0, 0, 16'd6);
        resume = 0;

        // WAIT state then sequential on ready
        pc_cur = 16'h0502; imem_ready = 0;
        step(16'h0000, 0, 0, 0, 0, 0, 16'd6);
        step(16'h0000, 0, 0, 0, 0, 0, 16'd7);
        imem_ready = 1;
        step(16'h0504, 1, 1, 0, 0, 0, 16'd8);

        // PEND with target overwritten by a newer branch
        pc_cur = 16'h0504; br_taken = 1; br_target = 16'h0700; imem_ready = 0;
        step(16'h0000, 0, 0, 1, 1, 0, 16'd8);
        br_target = 16'h0800;
        step(16'h0000, 0, 0, 1, 1, 0, 16'd9);
        br_taken = 0; imem_ready = 1;
        step(16'h0800, 1, 1, 1, 0, 0, 16'd10);

        // 6. enter PEND, then asynchronous reset mid-wait
        pc_cur = 16'h0800; br_taken = 1; br_target = 16'h0900; imem_ready = 0;
        step(16'h0000, 0, 0, 1, 1, 0, 16'd10);
        br_taken = 0;
        step(16'h0000, 0, 0, 1, 0, 0, 16'd11);
        rst_n = 0; imem_ready = 1;
        step(16'h0800, 1, 0, 0, 0, 0, 16'd0);
        rst_n = 1;
        step(16'h0802, 1, 1, 0, 0, 0, 16'd0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_ctrl
`default_nettype wire
